// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl
// Multiplexed N-digit 7-segment display controller. Scans hex digits onto a
// shared active-low segment bus with decimal points, leading-zero blanking,
// per-digit blink, PWM brightness and an anti-ghost guard at the start of
// each digit slot. New content is captured into pending registers on load and
// only becomes visible at a frame boundary, so a frame never shows a mix of
// old and new values.

module seg_display_ctrl #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_OVERFLOW = 2**19-1,
  parameter int GUARD_CYCLES     = 16,
  parameter int BRIGHT_BITS      = 4,
  parameter int BLINK_OVERFLOW   = 2**24-1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [3:0]             number [NUM_DIGITS],
  input  logic [NUM_DIGITS-1:0]  dp,
  input  logic [NUM_DIGITS-1:0]  blink_en,
  input  logic                   blank_lz,
  input  logic [BRIGHT_BITS-1:0] brightness,
  output logic [NUM_DIGITS-1:0]  digit_select,
  output logic [6:0]             led_select,
  output logic                   dp_n,
  output logic                   frame_start
);

  localparam int REFRESH_W = $clog2(REFRESH_OVERFLOW + 1);
  localparam int IDX_W     = $clog2(NUM_DIGITS);
  localparam int BLINK_W   = $clog2(BLINK_OVERFLOW + 1);

  localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_OVERFLOW);
  localparam logic [REFRESH_W-1:0] GUARD_LIMIT  = REFRESH_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0]     IDX_LAST     = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLINK_W-1:0]   BLINK_LAST   = BLINK_W'(BLINK_OVERFLOW);

  // Scan and timing counters
  logic [REFRESH_W-1:0]   refresh_cnt;
  logic [IDX_W-1:0]       idx;
  logic [BRIGHT_BITS-1:0] pwm_cnt;
  logic [BLINK_W-1:0]     blink_cnt;
  logic                   blink_phase;

  // Content currently being shown
  logic [3:0]             active_num [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  active_dp;
  logic [NUM_DIGITS-1:0]  active_blink;
  logic                   active_blank_lz;

  // Content waiting for the next frame boundary
  logic [3:0]             pending_num [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]  pending_dp;
  logic [NUM_DIGITS-1:0]  pending_blink;
  logic                   pending_blank_lz;
  logic                   pending_valid;

  // Next-state values of the registered outputs
  logic                   frame_end;
  logic [NUM_DIGITS-1:0]  upper_zero;
  logic [3:0]             cur_digit;
  logic                   lit;
  logic                   lz;
  logic [NUM_DIGITS-1:0]  anode_next;
  logic [6:0]             seg_next;
  logic                   dp_next;
  logic                   frame_start_next;

  // Active-low hex digit to {g,f,e,d,c,b,a} segment pattern
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign frame_end = (idx == IDX_LAST) && (refresh_cnt == REFRESH_LAST);

  // Slot timer, digit index, free-running PWM ramp and blink timebase
  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0;
      idx         <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (refresh_cnt == REFRESH_LAST) begin
        refresh_cnt <= '0;
        idx         <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Capture loads into pending and promote them to active only at frame end;
  // a load landing on the frame-end cycle itself goes straight to active
  always_ff @(posedge clk) begin
    if (reset) begin
      active_num       <= '{default: '0};
      active_dp        <= '0;
      active_blink     <= '0;
      active_blank_lz  <= 1'b0;
      pending_num      <= '{default: '0};
      pending_dp       <= '0;
      pending_blink    <= '0;
      pending_blank_lz <= 1'b0;
      pending_valid    <= 1'b0;
    end else if (frame_end && load) begin
      active_num      <= number;
      active_dp       <= dp;
      active_blink    <= blink_en;
      active_blank_lz <= blank_lz;
      pending_valid   <= 1'b0;
    end else if (load) begin
      pending_num      <= number;
      pending_dp       <= dp;
      pending_blink    <= blink_en;
      pending_blank_lz <= blank_lz;
      pending_valid    <= 1'b1;
    end else if (frame_end && pending_valid) begin
      active_num      <= pending_num;
      active_dp       <= pending_dp;
      active_blink    <= pending_blink;
      active_blank_lz <= pending_blank_lz;
      pending_valid   <= 1'b0;
    end
  end

  // upper_zero[k] is set when digit k and every more-significant digit are zero
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    upper_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      all_zero      = all_zero && (active_num[k] == 4'h0);
      upper_zero[k] = all_zero;
    end
  end

  // Decide what the current slot drives: anode gating, segments, dp and frame marker
  always_comb begin
    cur_digit        = active_num[idx];
    lit              = (refresh_cnt >= GUARD_LIMIT) &&
                       (pwm_cnt < brightness) &&
                       !(active_blink[idx] && blink_phase);
    lz               = active_blank_lz && (idx != '0) && upper_zero[idx];
    anode_next       = ~({{(NUM_DIGITS-1){1'b0}}, lit} << idx);
    seg_next         = lz ? 7'h7F : hex_to_seg(cur_digit);
    dp_next          = ~active_dp[idx];
    frame_start_next = (idx == '0) && (refresh_cnt == '0);
  end

  // Register every output so the pins never see combinational glitches
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_select <= '1;
      led_select   <= 7'h7F;
      dp_n         <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      digit_select <= anode_next;
      led_select   <= seg_next;
      dp_n         <= dp_next;
      frame_start  <= frame_start_next;
    end
  end

endmodule
